// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Logical, arithmetic and compare ops take one cycle. Shifts take one cycle
// per bit of shift amount.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   in_valid/ready  - input handshake; accept happens only in IDLE
//   operation, a, b - 4-bit op code and operands; b[SHW-1:0] is the shift amount
//   out_valid/ready - output handshake; the result is held while out_ready=0
//   result, zero    - registered result and result==0 flag
//   illegal         - set with out_valid when the accepted op code was illegal
module alu_exec_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      operation,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            illegal_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  cnt_q;
  logic [3:0]      op_q;

  logic [XLEN-1:0] alu_c;
  logic            legal_c;
  logic            is_shift_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] shift_step_c;

  assign shamt_c = b[SHW-1:0];

  // Single-cycle result; for shift codes this is the amount-0 result (a itself).
  always_comb begin
    alu_c      = '0;
    legal_c    = 1'b1;
    is_shift_c = 1'b0;
    case (operation)
      OP_AND:  alu_c = a & b;
      OP_OR:   alu_c = a | b;
      OP_ADD:  alu_c = a + b;
      OP_XOR:  alu_c = a ^ b;
      OP_SLTU: alu_c = XLEN'(a < b);
      OP_SUB:  alu_c = a - b;
      OP_SLT:  alu_c = XLEN'($signed(a) < $signed(b));
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_c      = a;
        is_shift_c = 1'b1;
      end
      default: legal_c = 1'b0;
    endcase
  end

  // One-bit shift of the accumulator for the captured shift kind.
  always_comb begin
    shift_step_c = '0;
    case (op_q)
      OP_SLL:  shift_step_c = {acc_q[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step_c = {1'b0, acc_q[XLEN-1:1]};
      default: shift_step_c = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      illegal_q   <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_shift_c && (shamt_c != '0)) begin
              acc_q   <= a;
              cnt_q   <= shamt_c;
              op_q    <= operation;
              state_q <= S_SHIFT;
            end else begin
              result_q    <= legal_c ? alu_c : '0;
              zero_q      <= legal_c ? (alu_c == '0) : 1'b1;
              illegal_q   <= ~legal_c;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= shift_step_c;
          cnt_q <= cnt_q - SHW'(1);
          // Last step writes straight into result so out_valid lands n+1 after accept.
          if (cnt_q == SHW'(1)) begin
            result_q    <= shift_step_c;
            zero_q      <= (shift_step_c == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued at issue
// time and compared when the unit hands the result over.
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      operation;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  typedef struct {
    logic [XLEN-1:0] r;
    logic            z;
    logic            il;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_exec_unit #(.XLEN(XLEN), .SHW(SHW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    exp_t e;
    int   sh;
    sh    = int'(y[SHW-1:0]);
    e.il  = 1'b0;
    e.lat = 1;
    case (op)
      4'd0:  e.r = x & y;
      4'd1:  e.r = x | y;
      4'd2:  e.r = x + y;
      4'd3:  e.r = x ^ y;
      4'd4:  e.r = (x < y) ? 32'd1 : 32'd0;
      4'd6:  e.r = x - y;
      4'd7:  e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  e.r = x << sh;
      4'd9:  e.r = x >> sh;
      4'd10: e.r = $unsigned($signed(x) >>> sh);
      default: begin
        e.r  = '0;
        e.il = 1'b1;
      end
    endcase
    if ((op inside {4'd8, 4'd9, 4'd10}) && sh != 0) e.lat = sh + 1;
    e.z = (e.r == '0);
    return e;
  endfunction

  // Issue one op from IDLE, wait for the result, apply `stall` cycles of
  // backpressure (with junk input traffic), then hand the result over.
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y, input int stall);
    exp_t            e;
    int              lat;
    logic            rdy_seen;
    logic            stable;
    logic [XLEN-1:0] r0;
    logic            z0;
    logic            il0;
    chk_eq($sformatf("in_ready_idle op%0d", op), 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    operation = op;
    a         = x;
    b         = y;
    out_ready = (stall == 0);
    exp_q.push_back(model(op, x, y));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    operation = 4'($urandom);
    lat       = 1;
    rdy_seen  = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) rdy_seen = 1'b1;
    e = exp_q.pop_front();
    chk_eq($sformatf("latency op%0d", op), 32'(lat), 32'(e.lat));
    chk_eq($sformatf("in_ready_busy op%0d", op), 32'(rdy_seen), 32'd0);
    if (stall > 0) begin
      r0 = result; z0 = zero; il0 = illegal;
      stable = 1'b1;
      for (int i = 0; i < stall; i++) begin
        in_valid  = 1'b1;
        operation = 4'd2;
        a         = $urandom;
        b         = $urandom;
        @(posedge clk); #1;
        if (result !== r0 || zero !== z0 || illegal !== il0 || !out_valid || in_ready) stable = 1'b0;
      end
      chk_eq($sformatf("held_stable op%0d", op), 32'(stable), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    chk_eq($sformatf("result op%0d", op), result, e.r);
    chk_eq($sformatf("zero op%0d", op), 32'(zero), 32'(e.z));
    chk_eq($sformatf("illegal op%0d", op), 32'(illegal), 32'(e.il));
    @(posedge clk); #1;
    chk_eq($sformatf("out_valid_drop op%0d", op), 32'(out_valid), 32'd0);
    chk_eq($sformatf("in_ready_back op%0d", op), 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] legal_ops [10];
    logic       ov_seen;
    legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst in_ready", 32'(in_ready), 32'd1);
    chk_eq("rst out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst result", result, 32'd0);
    chk_eq("rst zero", 32'(zero), 32'd1);
    chk_eq("rst illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    issue(4'd6, 32'h1234_5678, 32'h1234_5678, 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    issue(4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    issue(4'd10, 32'h8000_0000, 32'd31, 0);
    issue(4'd8, 32'hDEAD_BEEF, 32'd0, 0);
    issue(4'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3);
    issue(4'd5, 32'h1111_1111, 32'h2222_2222, 0);
    issue(4'd8, 32'h0000_0001, 32'd31, 0);
    issue(4'd9, 32'h8000_0000, 32'd1, 0);
    issue(4'd15, 32'h0, 32'h0, 0);

    // Reset four cycles into a 20-step SRL: nothing may come out afterwards.
    in_valid  = 1'b1;
    operation = 4'd9;
    a         = 32'hFFFF_0000;
    b         = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_eq("midrst out_valid", 32'(out_valid), 32'd0);
    chk_eq("midrst result", result, 32'd0);
    chk_eq("midrst in_ready", 32'(in_ready), 32'd1);
    chk_eq("midrst zero", 32'(zero), 32'd1);
    ov_seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen = 1'b1;
    end
    chk_eq("midrst no_emit", 32'(ov_seen), 32'd0);
    issue(4'd2, 32'd2, 32'd3, 0);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      logic [XLEN-1:0] y;
      op = (i % 6 == 5) ? 4'(11 + $urandom_range(0, 4)) : legal_ops[$urandom_range(0, 9)];
      y  = $urandom;
      if (op inside {4'd8, 4'd9, 4'd10}) y = 32'($urandom_range(0, 12));
      issue(op, $urandom, y, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
